// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 intervals, derived totals and polarities.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 4;
    localparam int CW_DEF       = 10;

    localparam bit POL_NEG = 1'b0;
    localparam bit POL_POS = 1'b1;

    // Total length of a line or frame; sync and back porch precede the active area.
    function automatic int line_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    localparam int H_TOTAL_DEF     = line_total(H_SYNC_DEF, H_BP_DEF, H_ACTIVE_DEF, H_FP_DEF);
    localparam int V_TOTAL_DEF     = line_total(V_SYNC_DEF, V_BP_DEF, V_ACTIVE_DEF, V_FP_DEF);
    localparam int H_ACT_START_DEF = H_SYNC_DEF + H_BP_DEF;
    localparam int V_ACT_START_DEF = V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the downstream pixel pipeline.
interface vga_timing_gen_if
    import vga_pkg::*;
#(
    parameter int CW = CW_DEF
);
    logic          en;
    logic          pixTick;
    logic          hSync;
    logic          vSync;
    logic          bright;
    logic [CW-1:0] hCount;
    logic [CW-1:0] vCount;
    logic [CW-1:0] xPix;
    logic [CW-1:0] yPix;
    logic          lineStart;
    logic          frameStart;

    modport master (
        input  en,
        output pixTick, hSync, vSync, bright, hCount, vCount, xPix, yPix, lineStart, frameStart
    );

    modport slave (
        output en,
        input  pixTick, hSync, vSync, bright, hCount, vCount, xPix, yPix, lineStart, frameStart
    );
endinterface

// File: rtl/pix_clk_en.sv
// Pixel-rate enable: a one-clk strobe every CLK_DIV system clocks, frozen while en is low.
module pix_clk_en
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;
    logic          div_last;

    // With CLK_DIV=1 div never leaves 0, so div_last is constant and the strobe follows en.
    assign div_last = (div == DIV_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= div_last ? '0 : div + DW'(1);
        end
    end

    assign pix_tick = en && div_last;
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Define VGA_OUT_REG_EN to register the
// decoded sync/bright/pixel outputs (one pixel period behind the counters).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter bit HS_POL   = POL_NEG,
    parameter bit VS_POL   = POL_NEG,
    parameter int CW       = CW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = line_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = line_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_BEG  = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_BEG  = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic          pix_tick;
    logic          h_last;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;

    logic          hs_d;
    logic          vs_d;
    logic          br_d;
    logic [CW-1:0] x_d;
    logic [CW-1:0] y_d;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk      (clk),
        .rst      (rst),
        .en       (vga.en),
        .pix_tick (pix_tick)
    );

    assign h_last = (h_count == H_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + CW'(1);
            end else begin
                h_count <= h_count + CW'(1);
            end
        end
    end

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        hs_d = (h_count < H_SYNC_END) ? HS_POL : ~HS_POL;
        vs_d = (v_count < V_SYNC_END) ? VS_POL : ~VS_POL;
        br_d = (h_count >= H_ACT_BEG) && (h_count <= H_ACT_END) &&
               (v_count >= V_ACT_BEG) && (v_count <= V_ACT_END);
        x_d  = br_d ? (h_count - H_ACT_BEG) : '0;
        y_d  = br_d ? (v_count - V_ACT_BEG) : '0;
    end

`ifdef VGA_OUT_REG_EN
    logic          hs_q;
    logic          vs_q;
    logic          br_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;

    // Loaded only on pixel ticks so the outputs change once per pixel and never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q <= HS_POL;
            vs_q <= VS_POL;
            br_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (pix_tick) begin
            hs_q <= hs_d;
            vs_q <= vs_d;
            br_q <= br_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign vga.hSync  = hs_q;
    assign vga.vSync  = vs_q;
    assign vga.bright = br_q;
    assign vga.xPix   = x_q;
    assign vga.yPix   = y_q;
`else
    assign vga.hSync  = hs_d;
    assign vga.vSync  = vs_d;
    assign vga.bright = br_d;
    assign vga.xPix   = x_d;
    assign vga.yPix   = y_d;
`endif

    assign vga.pixTick    = pix_tick;
    assign vga.hCount     = h_count;
    assign vga.vCount     = v_count;
    assign vga.lineStart  = pix_tick && h_last;
    assign vga.frameStart = pix_tick && h_last && (v_count == V_LAST);
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three vga_timing_gen builds (default, CLK_DIV=1, tiny positive-polarity raster).
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int unsigned h_act, h_fp, h_sync, h_bp;
        int unsigned v_act, v_fp, v_sync, v_bp;
        int unsigned clk_div;
        bit          hs_pol, vs_pol;
    } cfg_t;

`ifdef VGA_OUT_REG_EN
    localparam int unsigned LAG = 1;
`else
    localparam int unsigned LAG = 0;
`endif

    logic clk;
    logic rst;
    logic en;

    vga_timing_gen_if #(.CW(10)) ia ();
    vga_timing_gen_if #(.CW(10)) ib ();
    vga_timing_gen_if #(.CW(10)) ic ();

    assign ia.en = en;
    assign ib.en = en;
    assign ic.en = en;

    vga_timing_gen #(.CLK_DIV(4)) dut_a (.clk(clk), .rst(rst), .vga(ia));
    vga_timing_gen #(.CLK_DIV(1)) dut_b (.clk(clk), .rst(rst), .vga(ib));
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(2), .HS_POL(POL_POS), .VS_POL(POL_POS), .CW(10)
    ) dut_c (.clk(clk), .rst(rst), .vga(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    cfg_t        cfg [3];
    int unsigned pcnt     = 0;
    int unsigned cyc      = 0;
    string       phase    = "reset";
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] qc[$];

    bit          fs_seen  = 1'b0;
    int unsigned fs_cyc   = 0;
    int unsigned ls_cnt   = 0;
    int unsigned br_cnt   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] pack(input logic pt, input logic hs, input logic vs,
                                         input logic br, input logic ls, input logic fs,
                                         input logic [9:0] h, input logic [9:0] v,
                                         input logic [9:0] x, input logic [9:0] y);
        return {18'd0, pt, hs, vs, br, ls, fs, h, v, x, y};
    endfunction

    // pc = enabled clocks since reset release; the raster position follows from pixel ticks.
    function automatic logic [63:0] model(input cfg_t c, input int unsigned pc, input logic en_i);
        int unsigned ht, vt, ticks, h, v, dt, dh, dv, hb, vb;
        logic pt, ls, fs, hs, vs, br;
        logic [9:0] x, y;
        ht    = c.h_sync + c.h_bp + c.h_act + c.h_fp;
        vt    = c.v_sync + c.v_bp + c.v_act + c.v_fp;
        hb    = c.h_sync + c.h_bp;
        vb    = c.v_sync + c.v_bp;
        ticks = pc / c.clk_div;
        pt    = en_i && ((pc % c.clk_div) == c.clk_div - 1);
        h     = ticks % ht;
        v     = (ticks / ht) % vt;
        ls    = pt && (h == ht - 1);
        fs    = ls && (v == vt - 1);
        dt    = (ticks >= LAG) ? ticks - LAG : 0;
        dh    = dt % ht;
        dv    = (dt / ht) % vt;
        hs    = (dh < c.h_sync) ? c.hs_pol : !c.hs_pol;
        vs    = (dv < c.v_sync) ? c.vs_pol : !c.vs_pol;
        br    = (dh >= hb) && (dh < hb + c.h_act) && (dv >= vb) && (dv < vb + c.v_act);
        x     = br ? 10'(dh - hb) : 10'd0;
        y     = br ? 10'(dv - vb) : 10'd0;
        return pack(pt, hs, vs, br, ls, fs, 10'(h), 10'(v), x, y);
    endfunction

    task automatic step(input logic rst_v, input logic en_v);
        logic [63:0] obs_a, obs_b, obs_c;
        @(posedge clk);
        if (!rst && en) pcnt++;
        #1;
        rst = rst_v;
        en  = en_v;
        if (rst) pcnt = 0;
        qa.push_back(model(cfg[0], pcnt, en));
        qb.push_back(model(cfg[1], pcnt, en));
        qc.push_back(model(cfg[2], pcnt, en));
        @(negedge clk);
        cyc++;
        obs_a = pack(ia.pixTick, ia.hSync, ia.vSync, ia.bright, ia.lineStart, ia.frameStart,
                     ia.hCount, ia.vCount, ia.xPix, ia.yPix);
        obs_b = pack(ib.pixTick, ib.hSync, ib.vSync, ib.bright, ib.lineStart, ib.frameStart,
                     ib.hCount, ib.vCount, ib.xPix, ib.yPix);
        obs_c = pack(ic.pixTick, ic.hSync, ic.vSync, ic.bright, ic.lineStart, ic.frameStart,
                     ic.hCount, ic.vCount, ic.xPix, ic.yPix);
        check({phase, "_qa_level"}, 64'(qa.size()), 64'd1);
        check({phase, "_qb_level"}, 64'(qb.size()), 64'd1);
        check({phase, "_qc_level"}, 64'(qc.size()), 64'd1);
        if (qa.size() != 0) check({phase, "_a"}, obs_a, qa.pop_front());
        if (qb.size() != 0) check({phase, "_b"}, obs_b, qb.pop_front());
        if (qc.size() != 0) check({phase, "_c"}, obs_c, qc.pop_front());

        // Spot checks on the CLK_DIV=1 build with literal timing values.
        if (!rst && en) begin
            if (pcnt == 95 + LAG)  check("b_hsync_last_low", 64'(ib.hSync), 64'd0);
            if (pcnt == 96 + LAG)  check("b_hsync_high", 64'(ib.hSync), 64'd1);
            if (pcnt == H_TOTAL_DEF - 1) begin
                check("b_line_start", 64'(ib.lineStart), 64'd1);
                check("b_h_799", 64'(ib.hCount), 64'd799);
            end
            if (pcnt == H_TOTAL_DEF) begin
                check("b_wrap_h", 64'(ib.hCount), 64'd0);
                check("b_wrap_v", 64'(ib.vCount), 64'd1);
            end
            if (pcnt == V_ACT_START_DEF * H_TOTAL_DEF + H_ACT_START_DEF + LAG) begin
                check("b_bright_rise", 64'(ib.bright), 64'd1);
                check("b_x_first", 64'(ib.xPix), 64'd0);
                check("b_y_line35", 64'(ib.yPix), 64'd0);
            end
            if (pcnt == 35 * 800 + 143 + LAG) check("b_bright_pre", 64'(ib.bright), 64'd0);
            if (pcnt == 35 * 800 + 783 + LAG) check("b_x_last", 64'(ib.xPix), 64'd639);
            if (pcnt == 35 * 800 + 784 + LAG) check("b_bright_fall", 64'(ib.bright), 64'd0);
        end

        // Per-frame totals on the tiny raster; a frame spanning a pause or reset is not judged.
        if (rst || !en) begin
            fs_seen = 1'b0;
            ls_cnt  = 0;
            br_cnt  = 0;
        end else begin
            if (ic.pixTick && ic.bright) br_cnt++;
            if (ic.lineStart) ls_cnt++;
            if (ic.frameStart) begin
                if (fs_seen) begin
                    check("c_frame_clks", 64'(cyc - fs_cyc), 64'd240);
                    check("c_lines", 64'(ls_cnt), 64'd8);
                    check("c_bright_ticks", 64'(br_cnt), 64'd32);
                end
                fs_seen = 1'b1;
                fs_cyc  = cyc;
                ls_cnt  = 0;
                br_cnt  = 0;
            end
        end
    endtask

    initial begin
        cfg[0] = '{h_act: H_ACTIVE_DEF, h_fp: H_FP_DEF, h_sync: H_SYNC_DEF, h_bp: H_BP_DEF,
                   v_act: V_ACTIVE_DEF, v_fp: V_FP_DEF, v_sync: V_SYNC_DEF, v_bp: V_BP_DEF,
                   clk_div: 4, hs_pol: 1'b0, vs_pol: 1'b0};
        cfg[1] = cfg[0];
        cfg[1].clk_div = 1;
        cfg[2] = '{h_act: 8, h_fp: 2, h_sync: 3, h_bp: 2, v_act: 4, v_fp: 1, v_sync: 2, v_bp: 1,
                   clk_div: 2, hs_pol: 1'b1, vs_pol: 1'b1};
        rst = 1'b1;
        en  = 1'b0;

        repeat (3) step(1'b1, 1'b0);
        check("rst_a_h", 64'(ia.hCount), 64'd0);
        check("rst_a_hsync", 64'(ia.hSync), 64'd0);
        check("rst_a_vsync", 64'(ia.vSync), 64'd0);
        check("rst_a_tick", 64'(ia.pixTick), 64'd0);
        check("rst_c_hsync", 64'(ic.hSync), 64'd1);
        check("rst_c_vsync", 64'(ic.vSync), 64'd1);

        phase = "run";
        while (pcnt != 1600) step(1'b0, 1'b1);
        check("pre_hold_h", 64'(ia.hCount), 64'd400);

        phase = "hold";
        repeat (10) begin
            step(1'b0, 1'b0);
            check("hold_h", 64'(ia.hCount), 64'd400);
            check("hold_tick", 64'(ia.pixTick), 64'd0);
            check("hold_line_start", 64'(ib.lineStart), 64'd0);
        end

        phase = "resume";
        while (pcnt != 5200) step(1'b0, 1'b1);
        check("pre_rst_h", 64'(ia.hCount), 64'd500);
        check("pre_rst_v", 64'(ia.vCount), 64'd1);

        phase = "async_rst";
        step(1'b1, 1'b1);
        check("mid_rst_h", 64'(ia.hCount), 64'd0);
        check("mid_rst_v", 64'(ia.vCount), 64'd0);
        check("mid_rst_hsync", 64'(ia.hSync), 64'd0);
        check("mid_rst_xpix", 64'(ia.xPix), 64'd0);
        check("mid_rst_c_hsync", 64'(ic.hSync), 64'd1);
        step(1'b1, 1'b1);

        phase = "frames";
        repeat (30000) step(1'b0, 1'b1);

        check("sb_drain_a", 64'(qa.size()), 64'd0);
        check("sb_drain_b", 64'(qb.size()), 64'd0);
        check("sb_drain_c", 64'(qc.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
